// File: rtl/decode_stage_fwd_pkg.sv
// Shared types for the decode/operand-fetch stage (package decode_pkg).
// The DEC_* widths are the build-wide defaults the stage parameters start from.
package decode_pkg;
   localparam int DEC_XLEN = 64;
   localparam int DEC_NSRC = 2;
   localparam int DEC_NFWD = 3;
   localparam int DEC_AW   = 5;

   typedef logic [DEC_AW-1:0]   creg_addr_t;
   typedef logic [DEC_XLEN-1:0] word_t;

   typedef struct packed {
      logic       valid;
      creg_addr_t dst;
      logic       rdy;
      word_t      data;
   } fwd_src_t;

   typedef struct packed {
      logic                         valid;
      logic [63:0]                  pc;
      logic [31:0]                  instr;
      logic [DEC_NSRC*DEC_XLEN-1:0] src;
      creg_addr_t                   dst;
   } decode_out_t;
endpackage

// File: rtl/decode_stage_fwd_if.sv
// Fetch-side, register-file, forwarding and execute-side signals of the decode stage.
// master = surrounding pipeline, slave = the decode stage itself.
interface decode_stage_fwd_if #(
   parameter int XLEN = 64,
   parameter int NSRC = 2,
   parameter int NFWD = 3,
   parameter int AW   = 5
);
   logic                 in_valid;
   logic                 in_ready;
   logic [63:0]          in_pc;
   logic [31:0]          in_instr;
   logic [NSRC*AW-1:0]   in_src_addr;
   logic [NSRC-1:0]      in_src_use;
   logic [AW-1:0]        in_dst;
   logic [NSRC*AW-1:0]   rf_addr;
   logic [NSRC*XLEN-1:0] rf_data;
   logic [NFWD-1:0]      fwd_valid;
   logic [NFWD*AW-1:0]   fwd_dst;
   logic [NFWD-1:0]      fwd_rdy;
   logic [NFWD*XLEN-1:0] fwd_data;
   logic                 flush;
   logic                 out_valid;
   logic                 out_ready;
   logic [63:0]          out_pc;
   logic [31:0]          out_instr;
   logic [NSRC*XLEN-1:0] out_src;
   logic [AW-1:0]        out_dst;

   modport master (
      output in_valid, in_pc, in_instr, in_src_addr, in_src_use, in_dst,
      output rf_data, fwd_valid, fwd_dst, fwd_rdy, fwd_data, flush, out_ready,
      input  in_ready, rf_addr, out_valid, out_pc, out_instr, out_src, out_dst
   );

   modport slave (
      input  in_valid, in_pc, in_instr, in_src_addr, in_src_use, in_dst,
      input  rf_data, fwd_valid, fwd_dst, fwd_rdy, fwd_data, flush, out_ready,
      output in_ready, rf_addr, out_valid, out_pc, out_instr, out_src, out_dst
   );
endinterface

// File: rtl/decode_stage_fwd_fwd_select.sv
// Resolves one source operand against the forwarding window, youngest stage first.
// A matching stage that is not ready masks any older match and raises a hazard.
module fwd_select
   import decode_pkg::*;
#(
   parameter int NFWD = DEC_NFWD
) (
   input  creg_addr_t addr,
   input  logic       src_use,
   input  word_t      rf_data,
   input  fwd_src_t   fwd [NFWD],
   output word_t      operand,
   output logic       hazard
);
   logic found;

   always_comb begin
      operand = rf_data;
      hazard  = 1'b0;
      found   = 1'b0;
      if (addr == '0) begin
         operand = '0;
      end else begin
         for (int i = 0; i < NFWD; i++) begin
            if (!found && fwd[i].valid && (fwd[i].dst == addr)) begin
               found = 1'b1;
               if (fwd[i].rdy)
                  operand = fwd[i].data;
               else
                  hazard = src_use;
            end
         end
      end
   end
endmodule

// File: rtl/decode_stage_fwd.sv
// Decode/operand-fetch stage: resolves operands, stalls on unready producers, D/E register.
// Optional DECODE_STALL_CNT_EN adds saturating stall and backpressure counters.
module decode_stage_fwd
   import decode_pkg::*;
#(
   parameter int XLEN = DEC_XLEN,
   parameter int NSRC = DEC_NSRC,
   parameter int NFWD = DEC_NFWD,
   parameter int AW   = DEC_AW
) (
   input  logic                 clk,
   input  logic                 reset,
   decode_stage_fwd_if.slave    bus
`ifdef DECODE_STALL_CNT_EN
   ,
   output logic [31:0]          stall_cnt,
   output logic [31:0]          bp_cnt
`endif
);
   fwd_src_t             fwd [NFWD];
   word_t                operand [NSRC];
   logic [NSRC-1:0]      hazard;
   logic [NSRC*XLEN-1:0] src_res;
   logic                 stall;
   logic                 adv;
   decode_out_t          de_q;

   for (genvar i = 0; i < NFWD; i++) begin : g_fwd
      assign fwd[i].valid = bus.fwd_valid[i];
      assign fwd[i].dst   = bus.fwd_dst[i*AW +: AW];
      assign fwd[i].rdy   = bus.fwd_rdy[i];
      assign fwd[i].data  = bus.fwd_data[i*XLEN +: XLEN];
   end

   for (genvar s = 0; s < NSRC; s++) begin : g_src
      fwd_select #(.NFWD(NFWD)) u_sel (
         .addr    (bus.in_src_addr[s*AW +: AW]),
         .src_use (bus.in_src_use[s]),
         .rf_data (bus.rf_data[s*XLEN +: XLEN]),
         .fwd     (fwd),
         .operand (operand[s]),
         .hazard  (hazard[s])
      );
      assign src_res[s*XLEN +: XLEN] = operand[s];
   end

   assign stall        = bus.in_valid && (|hazard);
   assign adv          = !de_q.valid || bus.out_ready;
   assign bus.in_ready = (adv && !stall) || bus.flush;
   assign bus.rf_addr  = bus.in_src_addr;

   // Held entries keep the operands captured at acceptance; no re-resolution.
   always_ff @(posedge clk) begin
      if (reset) begin
         de_q <= '0;
      end else if (bus.flush) begin
         de_q.valid <= 1'b0;
      end else if (adv) begin
         if (stall) begin
            de_q.valid <= 1'b0;
         end else begin
            de_q.valid <= bus.in_valid;
            de_q.pc    <= bus.in_pc;
            de_q.instr <= bus.in_instr;
            de_q.src   <= src_res;
            de_q.dst   <= bus.in_dst;
         end
      end
   end

   assign bus.out_valid = de_q.valid;
   assign bus.out_pc    = de_q.pc;
   assign bus.out_instr = de_q.instr;
   assign bus.out_src   = de_q.src;
   assign bus.out_dst   = de_q.dst;

`ifdef DECODE_STALL_CNT_EN
   // Counters survive flush; only reset clears them.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
         bp_cnt    <= '0;
      end else begin
         if (adv && stall && !bus.flush && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
         if (de_q.valid && !bus.out_ready && (bp_cnt != '1))
            bp_cnt <= bp_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_decode_stage_fwd.sv
// Self-checking bench for decode_stage_fwd: directed scenarios then randomized traffic,
// every cycle compared against a behavioural model of the stage.
module tb_decode_stage_fwd;
   import decode_pkg::*;

   localparam int XL = 64;
   localparam int NS = 2;
   localparam int NF = 3;
   localparam int A  = 5;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   decode_stage_fwd_if #(.XLEN(XL), .NSRC(NS), .NFWD(NF), .AW(A)) bus ();

`ifdef DECODE_STALL_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] bp_cnt;
`endif

   decode_stage_fwd #(.XLEN(XL), .NSRC(NS), .NFWD(NF), .AW(A)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus)
`ifdef DECODE_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt),
      .bp_cnt    (bp_cnt)
`endif
   );

   int tests = 0;
   int fails = 0;

   // model of the D/E register
   bit           m_valid;
   logic [63:0]  m_pc;
   logic [31:0]  m_instr;
   logic [XL-1:0] m_src [NS];
   logic [A-1:0] m_dst;
   longint       m_stall_cnt;
   longint       m_bp_cnt;
   bit           last_rdy;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Operand rule: x0 reads zero; otherwise the youngest matching stage decides
   // (its data if ready, a hazard if not); no match reads the register file.
   function automatic void resolve(input int s, output logic [XL-1:0] val, output bit haz);
      int hits[$];
      logic [A-1:0] a;
      a   = bus.in_src_addr[s*A +: A];
      val = bus.rf_data[s*XL +: XL];
      haz = 1'b0;
      if (a == '0) begin
         val = '0;
         return;
      end
      for (int i = 0; i < NF; i++)
         if (bus.fwd_valid[i] && bus.fwd_dst[i*A +: A] == a) hits.push_back(i);
      if (hits.size() > 0) begin
         if (bus.fwd_rdy[hits[0]]) val = bus.fwd_data[hits[0]*XL +: XL];
         else                      haz = bus.in_src_use[s];
      end
   endfunction

   task automatic model_clear();
      m_valid = 0; m_pc = '0; m_instr = '0; m_dst = '0;
      for (int s = 0; s < NS; s++) m_src[s] = '0;
      m_stall_cnt = 0; m_bp_cnt = 0;
   endtask

   // Called just after a negedge with inputs set; returns at the next negedge.
   task automatic step();
      logic [XL-1:0] ops [NS];
      bit h, any_haz, stall, adv, exp_rdy, was_valid;
      any_haz = 0;
      #1;
      for (int s = 0; s < NS; s++) begin
         resolve(s, ops[s], h);
         any_haz |= h;
      end
      stall   = bus.in_valid && any_haz;
      adv     = !m_valid || bus.out_ready;
      exp_rdy = (adv && !stall) || bus.flush;
      check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      check("rf_addr", 64'(bus.rf_addr), 64'(bus.in_src_addr));
      last_rdy  = exp_rdy;
      was_valid = m_valid;
      @(posedge clk);
      if (reset) begin
         model_clear();
      end else begin
         if (adv && stall && !bus.flush && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
         if (was_valid && !bus.out_ready && m_bp_cnt < 64'hFFFF_FFFF) m_bp_cnt++;
         if (bus.flush) m_valid = 0;
         else if (adv && stall) m_valid = 0;
         else if (adv) begin
            m_valid = bus.in_valid;
            m_pc    = bus.in_pc;
            m_instr = bus.in_instr;
            m_dst   = bus.in_dst;
            for (int s = 0; s < NS; s++) m_src[s] = ops[s];
         end
      end
      #1;
      check("out_valid", 64'(bus.out_valid), 64'(m_valid));
      if (m_valid || reset) begin
         check("out_pc", bus.out_pc, m_pc);
         check("out_instr", 64'(bus.out_instr), 64'(m_instr));
         check("out_dst", 64'(bus.out_dst), 64'(m_dst));
         for (int s = 0; s < NS; s++) check("out_src", bus.out_src[s*XL +: XL], m_src[s]);
      end
`ifdef DECODE_STALL_CNT_EN
      check("stall_cnt", 64'(stall_cnt), 64'(m_stall_cnt));
      check("bp_cnt", 64'(bp_cnt), 64'(m_bp_cnt));
`endif
      @(negedge clk);
   endtask

   task automatic idle();
      bus.in_valid = 0; bus.in_pc = '0; bus.in_instr = '0; bus.in_src_addr = '0;
      bus.in_src_use = '0; bus.in_dst = '0; bus.rf_data = '0; bus.fwd_valid = '0;
      bus.fwd_dst = '0; bus.fwd_rdy = '0; bus.fwd_data = '0; bus.flush = 0; bus.out_ready = 1;
   endtask

   task automatic set_fwd(input int i, input bit v, input int dst, input bit rdy, input logic [63:0] d);
      bus.fwd_valid[i]      = v;
      bus.fwd_dst[i*A +: A] = A'(dst);
      bus.fwd_rdy[i]        = rdy;
      bus.fwd_data[i*XL +: XL] = d;
   endtask

   task automatic set_instr(input logic [63:0] pc, input int s0, input int s1, input bit [1:0] use_m, input int dst);
      bus.in_valid = 1; bus.in_pc = pc; bus.in_instr = pc[31:0] ^ 32'h1357_9BDF;
      bus.in_src_addr = {A'(s1), A'(s0)}; bus.in_src_use = use_m; bus.in_dst = A'(dst);
      bus.rf_data = {64'h1111_0000_0000_0001 + pc, 64'h2222_0000_0000_0002 + pc};
   endtask

   initial begin
      logic [63:0] held_pc;
      idle();
      reset = 1;
      model_clear();
      @(posedge clk); @(posedge clk); @(negedge clk);
      // reset state
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_pc", bus.out_pc, 64'd0);
      check("rst_out_instr", 64'(bus.out_instr), 64'd0);
      check("rst_out_src", bus.out_src[63:0], 64'd0);
      check("rst_out_dst", 64'(bus.out_dst), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      reset = 0;

      // forward priority: youngest wins, then next youngest
      set_fwd(0, 1, 5, 1, 64'hA); set_fwd(1, 1, 5, 1, 64'hB); set_fwd(2, 1, 5, 1, 64'hC);
      set_instr(64'h100, 5, 0, 2'b11, 9);
      step();
      check("prio_E", bus.out_src[63:0], 64'hA);
      bus.fwd_valid[0] = 0;
      set_instr(64'h104, 5, 0, 2'b11, 9);
      step();
      check("prio_M", bus.out_src[63:0], 64'hB);

      // load-use stall, then producer ready in M
      idle();
      set_fwd(0, 1, 7, 0, 64'h70);
      set_instr(64'h200, 0, 7, 2'b10, 3);
      step();
      check("lu_bubble", 64'(bus.out_valid), 64'd0);
      set_fwd(0, 0, 0, 0, 64'h0); set_fwd(1, 1, 7, 1, 64'h77);
      step();
      check("lu_src1", bus.out_src[127:64], 64'h77);

      // zero and unused sources never stall
      idle();
      set_fwd(0, 1, 0, 0, 64'hDEAD); set_fwd(1, 1, 3, 0, 64'hBEEF);
      set_instr(64'h300, 0, 3, 2'b01, 4);
      step();
      check("x0_src0", bus.out_src[63:0], 64'd0);

      // backpressure: payload holds even if forwarding data changes
      held_pc = bus.out_pc;
      bus.out_ready = 0;
      idle(); bus.out_ready = 0;
      set_fwd(1, 1, 3, 1, 64'h9999);
      set_instr(64'h400, 3, 0, 2'b01, 6);
      for (int k = 0; k < 3; k++) step();
      check("bp_pc_hold", bus.out_pc, held_pc);
      bus.out_ready = 1;
      step();
      check("bp_release_pc", bus.out_pc, 64'h400);

      // flush during stall drops the instruction without re-issue
      idle();
      set_fwd(0, 1, 8, 0, 64'h80);
      set_instr(64'h500, 8, 0, 2'b01, 2);
      step();
      bus.flush = 1;
      step();
      idle();
      step();
      check("flush_no_dup", 64'(bus.out_valid), 64'd0);

      // reset mid-stall
      set_fwd(0, 1, 8, 0, 64'h80);
      set_instr(64'h600, 8, 0, 2'b01, 2);
      step();
      reset = 1;
      step();
      reset = 0;
      set_fwd(0, 0, 0, 0, 64'h0);
      step();

      // counters: 4 stall cycles then 2 backpressure cycles
      idle();
      reset = 1; step(); reset = 0;
      set_fwd(0, 1, 9, 0, 64'h90);
      set_instr(64'h700, 9, 0, 2'b01, 1);
      for (int k = 0; k < 4; k++) step();
      set_fwd(0, 0, 0, 0, 64'h0);
      step();
      idle(); bus.out_ready = 0;
      step(); step();
`ifdef DECODE_STALL_CNT_EN
      check("cnt_stall4", 64'(stall_cnt), 64'd4);
      check("cnt_bp2", 64'(bp_cnt), 64'd2);
      reset = 1; step(); reset = 0;
      check("cnt_rst_stall", 64'(stall_cnt), 64'd0);
      check("cnt_rst_bp", 64'(bp_cnt), 64'd0);
`else
      reset = 1; step(); reset = 0;
`endif

      // randomized traffic, pending instructions held until accepted
      idle();
      last_rdy = 1;
      for (int n = 0; n < 400; n++) begin
         if (!(bus.in_valid && !last_rdy) || reset) begin
            bus.in_valid    = ($urandom_range(0, 3) != 0);
            bus.in_pc       = {$urandom, $urandom};
            bus.in_instr    = $urandom;
            bus.in_src_addr = {A'($urandom_range(0, 7)), A'($urandom_range(0, 7))};
            bus.in_src_use  = 2'($urandom_range(0, 3));
            bus.in_dst      = A'($urandom_range(0, 31));
         end
         bus.rf_data = {$urandom, $urandom, $urandom, $urandom};
         for (int i = 0; i < NF; i++)
            set_fwd(i, $urandom_range(0, 1), $urandom_range(0, 7),
                    ($urandom_range(0, 3) != 0), {$urandom, $urandom});
         bus.flush     = ($urandom_range(0, 15) == 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         reset         = ($urandom_range(0, 99) == 0);
         step();
      end
      reset = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
